// File: rtl/tagger_edge_synthesizer.sv
// tagger_edge_synthesizer
//
// Purpose:
//   Turns (cycle, subtime, width) events back into parallel sample words that
//   carry a falling edge at the requested sub-sample position. It takes the
//   place of the input deserializer so the falling-edge BCD converter can be
//   driven in loopback and self-test.
//
//   An event with end position E = T*N + S (exclusive) and width W drives the
//   samples in [E-W, E) high. All other samples are low. Only one event is
//   held at a time. The next event can be accepted during the cycle in which
//   the held event's last word is computed.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       synchronous active-low reset
//   in_valid    an event is offered
//   in_ready    the block can accept an event this cycle (combinational)
//   in_time     coarse cycle T of the falling edge
//   in_subtime  index S of the first low sample after the edge
//   in_width    pulse width W in samples
//   samples     registered sample word, bit 0 is the earliest sample
//   word_index  coarse cycle of the word currently on samples
//   busy        an event is being held
//   late_error  one-cycle pulse when an event is dropped as late
//   late_count  saturating count of late events
module tagger_edge_synthesizer #(
    parameter int BITS       = 4,
    parameter int TIME_BITS  = 32,
    parameter int WIDTH_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TIME_BITS-1:0]   in_time,
    input  logic [BITS-1:0]        in_subtime,
    input  logic [WIDTH_BITS-1:0]  in_width,
    output logic [(1<<BITS)-1:0]   samples,
    output logic [TIME_BITS-1:0]   word_index,
    output logic                   busy,
    output logic                   late_error,
    output logic [15:0]            late_count
);

    localparam int N  = 1 << BITS;
    localparam int PW = TIME_BITS + BITS;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, state_next;

    logic [TIME_BITS-1:0] now;
    logic [PW-1:0]        ev_begin;
    logic [PW-1:0]        ev_end;

    logic [PW-1:0]        cur_base;
    logic [PW-1:0]        next_base;
    logic                 active_done;

    logic [PW-1:0]        new_end;
    logic [PW-1:0]        new_width;
    logic [PW-1:0]        new_begin;
    logic                 accept;
    logic                 zero_width;
    logic                 is_late;
    logic                 load_event;
    logic                 late_hit;

    logic [N-1:0]         next_samples;

    // Absolute sample positions of the word being computed now and of the
    // word after it. The counter wraps freely; there is no wrap compensation.
    assign cur_base  = {now, {BITS{1'b0}}};
    assign next_base = {now + TIME_BITS'(1), {BITS{1'b0}}};

    // The held event finishes in this word once its end does not reach past
    // the start of the next word. That is also when a new event may enter.
    assign active_done = (ev_end <= next_base);
    assign in_ready    = (state == IDLE) || active_done;

    // A new event only becomes visible from word now+1. Its start must not
    // fall before that word, and E < W means the start would underflow.
    assign new_end    = {in_time, in_subtime};
    assign new_width  = PW'(in_width);
    assign new_begin  = new_end - new_width;
    assign accept     = in_valid && in_ready;
    assign zero_width = (in_width == '0);
    assign is_late    = (new_begin < next_base) || (new_end < new_width);
    assign load_event = accept && !zero_width && !is_late;
    assign late_hit   = accept && !zero_width && is_late;

    assign busy = (state == ACTIVE);

    // Next-state logic. A held event retires after its last word. A load
    // takes priority over that retirement. A late or zero-width offer leaves
    // nothing held, because it can only be accepted when the current event
    // retires anyway.
    always_comb begin
        state_next = state;
        if (state == ACTIVE && active_done) begin
            state_next = IDLE;
        end
        if (load_event) begin
            state_next = ACTIVE;
        end else if (late_hit) begin
            state_next = IDLE;
        end
    end

    // Sample word for word index 'now'. Each bit is high when its absolute
    // position lies inside the held pulse [ev_begin, ev_end).
    always_comb begin
        logic [PW-1:0] pos;
        next_samples = '0;
        pos          = '0;
        for (int i = 0; i < N; i++) begin
            pos = cur_base | PW'(i);
            next_samples[i] = (state == ACTIVE) &&
                              (pos >= ev_begin) && (pos < ev_end);
        end
    end

    // Counter, state, event registers and outputs. samples and word_index
    // update together, one cycle after 'now' held that word index. Reset
    // drops any held event, so no partial pulse appears after release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            now        <= '0;
            state      <= IDLE;
            ev_begin   <= '0;
            ev_end     <= '0;
            samples    <= '0;
            word_index <= '0;
            late_error <= 1'b0;
            late_count <= '0;
        end else begin
            now        <= now + TIME_BITS'(1);
            state      <= state_next;
            samples    <= next_samples;
            word_index <= now;
            late_error <= late_hit;
            if (late_hit && (late_count != 16'hFFFF)) begin
                late_count <= late_count + 16'd1;
            end
            if (load_event) begin
                ev_begin <= new_begin;
                ev_end   <= new_end;
            end
        end
    end

endmodule

// File: tb/tb_tagger_edge_synthesizer.sv
// tb_tagger_edge_synthesizer
//
// Purpose:
//   Directed bench for tagger_edge_synthesizer with BITS=4 (N=16). It walks
//   through these cases in order:
//     - in-word pulse
//     - word-spanning pulse
//     - late and zero-width events
//     - back-to-back events
//     - reset mid-pulse
//     - word-boundary edge
//     - underflow
//   Expected words are computed by hand from E = T*16+S and B = E-W.
//
// Ports: none (top-level bench).
module tb_tagger_edge_synthesizer;

    localparam int BITS       = 4;
    localparam int TIME_BITS  = 32;
    localparam int WIDTH_BITS = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [TIME_BITS-1:0]  in_time;
    logic [BITS-1:0]       in_subtime;
    logic [WIDTH_BITS-1:0] in_width;
    logic [15:0]           samples;
    logic [TIME_BITS-1:0]  word_index;
    logic                  busy;
    logic                  late_error;
    logic [15:0]           late_count;

    int          test_count = 0;
    int          fail_count = 0;
    logic [31:0] tb_now;
    logic [15:0] word_log [int];

    tagger_edge_synthesizer #(
        .BITS       (BITS),
        .TIME_BITS  (TIME_BITS),
        .WIDTH_BITS (WIDTH_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_time    (in_time),
        .in_subtime (in_subtime),
        .in_width   (in_width),
        .samples    (samples),
        .word_index (word_index),
        .busy       (busy),
        .late_error (late_error),
        .late_count (late_count)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle counter. It matches the expected value of the
    // internal 'now' during the cycle that follows each rising edge.
    always @(posedge clk) begin
        tb_now <= rst_n ? tb_now + 32'd1 : 32'd0;
    end

    // Record every output word by its index, away from the active edge.
    always @(negedge clk) begin
        word_log[int'(word_index)] = samples;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to the cycle in which now == k, with a bounded wait.
    task automatic wait_now(input int k);
        int budget = 200;
        while (tb_now != 32'(k) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            test_count++;
            fail_count++;
            $display("[TB] FAIL wait_now: now %0d required %0d", tb_now, k);
        end
    endtask

    // Offer an event, hold it until in_ready, then let it be accepted.
    // Returns one cycle after the accept.
    task automatic apply_stimulus(input int t, input int s, input int w);
        int budget = 64;
        in_time    = 32'(t);
        in_subtime = 4'(s);
        in_width   = 8'(w);
        in_valid   = 1'b1;
        while (!in_ready && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            test_count++;
            fail_count++;
            $display("[TB] FAIL accept_timeout: in_ready %0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_time    = '0;
        in_subtime = '0;
        in_width   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_samples",    32'(samples),    32'h0);
        check_output("reset_word_index", word_index,      32'h0);
        check_output("reset_busy",       32'(busy),       32'h0);
        check_output("reset_in_ready",   32'(in_ready),   32'h1);
        check_output("reset_late_error", 32'(late_error), 32'h0);
        check_output("reset_late_count", 32'(late_count), 32'h0);
        rst_n = 1'b1;

        // In-word pulse: E=165, B=162, so word 10 has bits 2..4 high.
        wait_now(2);
        apply_stimulus(10, 5, 3);
        check_output("inword_busy", 32'(busy), 32'h1);
        wait_now(11);
        check_output("inword_latency_word", 32'(samples), 32'h001C);
        check_output("inword_latency_idx",  word_index,   32'd10);
        wait_now(13);
        check_output("inword_w9",  32'(word_log[9]),  32'h0);
        check_output("inword_w10", 32'(word_log[10]), 32'h001C);
        check_output("inword_w11", 32'(word_log[11]), 32'h0);

        // Word-spanning pulse: E=322, B=316.
        wait_now(14);
        apply_stimulus(20, 2, 6);
        wait_now(20);
        check_output("span_busy_last_word", 32'(busy), 32'h1);
        wait_now(21);
        check_output("span_busy_dropped", 32'(busy), 32'h0);
        wait_now(22);
        check_output("span_w18", 32'(word_log[18]), 32'h0);
        check_output("span_w19", 32'(word_log[19]), 32'hF000);
        check_output("span_w20", 32'(word_log[20]), 32'h0003);

        // Late: B=484 lies before word 31 (position 496).
        wait_now(30);
        apply_stimulus(30, 8, 4);
        check_output("late_pulse", 32'(late_error), 32'h1);
        check_output("late_count1", 32'(late_count), 32'h1);
        check_output("late_busy", 32'(busy), 32'h0);
        wait_now(32);
        check_output("late_pulse_once", 32'(late_error), 32'h0);

        // Zero width: silently discarded.
        wait_now(33);
        apply_stimulus(50, 0, 0);
        check_output("zero_no_error", 32'(late_error), 32'h0);
        check_output("zero_count",    32'(late_count), 32'h1);
        check_output("zero_busy",     32'(busy),       32'h0);
        wait_now(35);
        check_output("late_no_samples_w30", 32'(word_log[30]), 32'h0);
        check_output("late_no_samples_w31", 32'(word_log[31]), 32'h0);

        // Back-to-back. A: E=644, B=642. Second event: E=673, B=659.
        wait_now(36);
        apply_stimulus(40, 4, 2);
        in_time    = 32'd42;
        in_subtime = 4'd1;
        in_width   = 8'd14;
        in_valid   = 1'b1;
        wait_now(39);
        check_output("b2b_not_ready", 32'(in_ready), 32'h0);
        wait_now(40);
        check_output("b2b_ready", 32'(in_ready), 32'h1);
        apply_stimulus(42, 1, 14);
        check_output("b2b_no_late", 32'(late_error), 32'h0);
        wait_now(44);
        check_output("b2b_w40", 32'(word_log[40]), 32'h000C);
        check_output("b2b_w41", 32'(word_log[41]), 32'hFFF8);
        check_output("b2b_w42", 32'(word_log[42]), 32'h0001);
        check_output("b2b_w43", 32'(word_log[43]), 32'h0);

        // Start in the same word as the previous end: late (B=776 < 784).
        apply_stimulus(48, 4, 2);
        apply_stimulus(48, 10, 2);
        check_output("same_word_late", 32'(late_error), 32'h1);
        check_output("same_word_count", 32'(late_count), 32'h2);
        wait_now(51);
        check_output("same_word_w48", 32'(word_log[48]), 32'h000C);
        check_output("same_word_w49", 32'(word_log[49]), 32'h0);

        // Reset mid-pulse: E=960, B=912 (word 57 fully high).
        wait_now(52);
        apply_stimulus(60, 0, 48);
        wait_now(58);
        check_output("pre_reset_busy", 32'(busy),    32'h1);
        check_output("pre_reset_w57",  32'(samples), 32'hFFFF);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_output("midreset_samples",    32'(samples),    32'h0);
        check_output("midreset_busy",       32'(busy),       32'h0);
        check_output("midreset_late_count", 32'(late_count), 32'h0);
        check_output("midreset_word_index", word_index,      32'h0);
        check_output("midreset_in_ready",   32'(in_ready),   32'h1);
        wait_now(2);
        check_output("post_reset_word_index1", word_index,   32'd1);
        wait_now(3);
        check_output("post_reset_word_index2", word_index,   32'd2);
        check_output("post_reset_no_pulse",    32'(samples), 32'h0);

        // Boundary edge, accepted at the latest possible cycle: E=80, B=79.
        apply_stimulus(5, 0, 1);
        wait_now(7);
        check_output("edge_w3", 32'(word_log[3]), 32'h0);
        check_output("edge_w4", 32'(word_log[4]), 32'h8000);
        check_output("edge_w5", 32'(word_log[5]), 32'h0);

        // Underflow: E=2 is smaller than W=5.
        wait_now(8);
        apply_stimulus(0, 2, 5);
        check_output("underflow_late",  32'(late_error), 32'h1);
        check_output("underflow_count", 32'(late_count), 32'h1);
        check_output("underflow_busy",  32'(busy),       32'h0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
